// File: rtl/snake_pkg.sv
// Shared steering definitions: direction codes, the "no command" push value
// and the direction -> active-low one-hot encoder used by the head updater.
package snake_pkg;

  localparam logic [1:0] UP    = 2'd0;
  localparam logic [1:0] DOWN  = 2'd1;
  localparam logic [1:0] RIGHT = 2'd2;
  localparam logic [1:0] LEFT  = 2'd3;

  localparam logic [3:0] PUSH_NONE = 4'b1111;

  // Active-low one-hot: the selected direction's bit is 0, all others 1.
  function automatic logic [3:0] dir_to_push(input logic [1:0] dir);
    logic [3:0] vec;
    vec      = PUSH_NONE;
    vec[dir] = 1'b0;
    return vec;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchronizer, stability counter and debounced level.
// The raw input is active-low, so synchronizer and stable flops reset to 1
// (released). press pulses for one cycle when the debounced level falls.
module btn_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic stable,
  output logic press
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
    end
  end

  // Accept a level change only after it has persisted for DB_CYCLES cycles;
  // any return to the stable level restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      stable <= 1'b1;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_b == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt    <= '0;
        stable <= sync_b;
        press  <= ~sync_b;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dir_cmd_capture.sv
// Steering front end: debounces the four direction buttons, picks one press
// per cycle (UP > DOWN > RIGHT > LEFT) and holds it until a move tick
// consumes it. Define SNAKE_DIR_QUEUE_EN to hold up to two commands in a
// FIFO instead of a single last-press-wins register.
module dir_cmd_capture #(
  parameter int DB_CYCLES = 500000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [3:0] i_Btn,
  input  logic       i_Step,
  output logic [3:0] o_Push,
  output logic       o_Valid,
  output logic [3:0] o_Level
);

  import snake_pkg::*;

  logic [3:0] stable;
  logic [3:0] press;
  logic       ev_any;
  logic [1:0] ev_dir;

  for (genvar g = 0; g < 4; g++) begin : g_btn
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk   (i_Clk),
      .rst   (i_Rst),
      .btn   (i_Btn[g]),
      .stable(stable[g]),
      .press (press[g])
    );
  end

  assign o_Level = ~stable;

  // Fixed-priority pick when several presses land in the same cycle.
  always_comb begin
    ev_any = |press;
    ev_dir = LEFT;
    if (press[UP])         ev_dir = UP;
    else if (press[DOWN])  ev_dir = DOWN;
    else if (press[RIGHT]) ev_dir = RIGHT;
  end

  logic [3:0] push_q;
  logic [3:0] push_d;
  logic       valid_q;

`ifdef SNAKE_DIR_QUEUE_EN
  // push_q is the FIFO head and is kept at PUSH_NONE when empty, so o_Push
  // comes straight from a flop.
  logic [3:0] tail_q;
  logic [3:0] tail_d;
  logic [1:0] cnt_q;
  logic [1:0] cnt_d;

  // Pop first, then push; a push into a full FIFO replaces the tail.
  always_comb begin
    push_d = push_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (i_Step && cnt_q != 2'd0) begin
      push_d = (cnt_q == 2'd2) ? tail_q : PUSH_NONE;
      tail_d = PUSH_NONE;
      cnt_d  = cnt_q - 2'd1;
    end
    if (ev_any) begin
      if (cnt_d == 2'd0) begin
        push_d = dir_to_push(ev_dir);
        cnt_d  = 2'd1;
      end else begin
        tail_d = dir_to_push(ev_dir);
        cnt_d  = 2'd2;
      end
    end
  end

  // FIFO storage.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      push_q  <= PUSH_NONE;
      tail_q  <= PUSH_NONE;
      cnt_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      push_q  <= push_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      valid_q <= (cnt_d != 2'd0);
    end
  end
`else
  // Newest press wins; a tick with no new press clears the entry.
  always_comb begin
    push_d = push_q;
    if (ev_any)      push_d = dir_to_push(ev_dir);
    else if (i_Step) push_d = PUSH_NONE;
  end

  // Single pending command register.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      push_q  <= PUSH_NONE;
      valid_q <= 1'b0;
    end else begin
      push_q  <= push_d;
      valid_q <= (push_d != PUSH_NONE);
    end
  end
`endif

  assign o_Push  = push_q;
  assign o_Valid = valid_q;

endmodule

// File: doc/dir_cmd_capture.md
# dir_cmd_capture

Front end of the snake's steering path: takes the four raw, active-low, bouncing direction buttons and synchronizes and debounces them. It converts each clean press into a held direction command, presented as the active-low one-hot push vector that the head-update logic consumes on every move tick. A command is held until a move tick consumes it, so the game no longer needs the button to be physically down at the instant of the tick.

## Interface
- DB_CYCLES, 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz); must be ≥2.
- CNT_W, $clog2(DB_CYCLES): debounce counter width; derived, not overridden.
- i_Clk  in  1  system clock; all state on rising edge.
- i_Rst  in  1  asynchronous, active-high reset.
- i_Btn  in  4  raw buttons, active-low, asynchronous; bit index UP=0, DOWN=1, RIGHT=2, LEFT=3.
- i_Step  in  1  one-cycle move tick from the game timer; consumes the current command.
- o_Push  out  4  active-low one-hot pending command; 4'b1111 = none; drives the head updater's push input.
- o_Valid  out  1  high while a command is pending (o_Push != 4'b1111).
- o_Level  out  4  debounced button levels, active-high pressed, for display/debug.

## Operation
- Per button: 2-FF synchronizer, then debounce. Counter increments while synced ≠ stable. On the count of DB_CYCLES-1, stable takes synced and the counter clears. The counter clears whenever synced = stable; any bounce restarts the count.
- Press event: one-cycle pulse on a stable 1→0 transition. Releases generate nothing.
- Multiple press events in one cycle: only one is taken, priority UP > DOWN > RIGHT > LEFT.
- Pending register (macro off): single entry; last press wins and overwrites any unconsumed command.
- i_Step with a command pending: the command is consumed and the entry clears at that edge. i_Step with nothing pending: no effect.
- Simultaneous i_Step and press event: the old entry is consumed and the new press is loaded; o_Push shows the new command the next cycle.
- Reversal filtering is not done here; the head updater rejects reversals.
- Reset mid-debounce: all counters clear and all stable levels go to released; a button still held after reset produces a press once it has been stable for DB_CYCLES.

## Timing
- Reset values: o_Push=4'b1111, o_Valid=0, o_Level=4'b0000, synchronizer and stable flops=1, counters=0, queue empty.
- Press latency: 2 sync cycles + DB_CYCLES cycles + 1 cycle to pending register. o_Push, o_Valid and o_Level are all registered.
- The consumer samples o_Push in the same cycle i_Step is high; the entry is gone the cycle after.
- Counter never exceeds DB_CYCLES-1; no wrap.

## Configuration
- SNAKE_DIR_QUEUE_EN defined: pending storage becomes a 2-entry FIFO so two quick turns between ticks are both executed, in order.
  - Push when full overwrites the tail (newest) entry and keeps the head.
  - i_Step pops the head.
  - Simultaneous pop and push when full: pop, then push; no loss.
  - o_Push shows the head entry; o_Valid means "not empty".
- Undefined: single last-press-wins register as in Operation.

## Structure
- Shared package snake_pkg holds:
  - direction constants UP/DOWN/RIGHT/LEFT (0..3);
  - PUSH_NONE = 4'b1111;
  - a function mapping a 2-bit direction to an active-low one-hot vector.
- Sub-module btn_debounce (synchronizer + counter + stable level + press pulse, parameter DB_CYCLES), instantiated four times.
- Top level holds the priority select and the pending register/FIFO.

## Test plan
All scenarios use DB_CYCLES=4.
- Reset: assert i_Rst mid-simulation with i_Btn[0]=0 held -> o_Push=4'b1111, o_Valid=0, o_Level=0 immediately.
- Clean press:
  - i_Btn=4'b1101 (DOWN) held -> o_Push=4'b1101 exactly 2+4+1 cycles later.
  - Then pulse i_Step -> o_Push=4'b1111 next cycle.
- Bounce: toggle i_Btn[2] every 2 cycles for 20 cycles, then release -> no press event; o_Valid stays 0.
- Overwrite and simultaneity:
  - UP press, then LEFT press before any i_Step -> o_Push=4'b0111 (macro off).
  - A press landing in the i_Step cycle -> the new direction appears.
  - Same-cycle UP and RIGHT presses -> 4'b1110.
- Queue (SNAKE_DIR_QUEUE_EN):
  - Presses RIGHT, UP, DOWN with no tick -> o_Push=4'b1011.
  - After one i_Step -> 4'b1101.
  - After a second i_Step -> 4'b1111.
- Hold: keep DOWN pressed across 3 ticks -> exactly one command delivered; no auto-repeat.
